fp_to_tc_serial: RTL

Sequential decoder that takes the lab's compact floating-point word (sign S, exponent E, significand F) and rebuilds the 12-bit two's-complement value F·2^E, negated when S=1. It is the inverse path of the 12-bit two's-complement to floating-point encoder chain. It sits downstream of that encoder for round-trip checking. A barrel shifter is avoided: the magnitude is built by one left shift per clock, then converted from sign-magnitude back to two's complement. Transfers use valid/ready handshakes on both sides.

---
 rtl/fp_to_tc_serial_if.sv | 26 ++
 rtl/fp_to_tc_serial.sv | 84 ++++++++
 2 files changed

// File: rtl/fp_to_tc_serial_if.sv
// Handshake bundle for the floating-point to two's-complement decoder.
// master drives the input word and accepts results; slave is the decoder.
interface fp_to_tc_serial_if #(
    parameter int unsigned EXP_W = 3,
    parameter int unsigned MAN_W = 4,
    parameter int unsigned OUT_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic             S;
    logic [EXP_W-1:0] E;
    logic [MAN_W-1:0] F;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] D;

    modport master (
        output in_valid, S, E, F, out_ready,
        input  in_ready, out_valid, D
    );

    modport slave (
        input  in_valid, S, E, F, out_ready,
        output in_ready, out_valid, D
    );
endinterface

// File: rtl/fp_to_tc_serial.sv
// Serial decoder: rebuilds the two's-complement value F*2^E (negated when S=1)
// using one left shift per clock instead of a barrel shifter.
module fp_to_tc_serial #(
    parameter int unsigned EXP_W = 3,
    parameter int unsigned MAN_W = 4,
    parameter int unsigned OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    fp_to_tc_serial_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic               sgn_q, sgn_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   mag_q, mag_d;
    logic [OUT_W-1:0]   d_q, d_d;
    logic               out_valid_q, out_valid_d;

    // Ready only when idle; reset forces it low so nothing is accepted during reset.
    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.D         = d_q;

    // Next-state logic: latch the word, shift one bit per cycle, then hold the result.
    always_comb begin
        state_d     = state_q;
        sgn_d       = sgn_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sgn_d   = bus.S;
                    cnt_d   = bus.E;
                    mag_d   = {{(OUT_W-MAN_W){1'b0}}, bus.F};
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - EXP_W'(1);
                end else begin
                    // Negative zero wraps back to 0 here, never to the most negative code.
                    d_d         = sgn_q ? (~mag_q + OUT_W'(1)) : mag_q;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset that also discards any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sgn_q       <= 1'b0;
            cnt_q       <= '0;
            mag_q       <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sgn_q       <= sgn_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
